// File: rtl/camera_sched_pkg.sv
// camera_sched_pkg: shared types, fixed-point constants and reset vectors for the camera scheduler
package camera_sched_pkg;
    localparam int POS_WIDTH    = 18;
    localparam int SINCOS_WIDTH = 16;
    localparam int FRAC         = 14;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;

    typedef logic signed [POS_WIDTH-1:0]    pos_t;
    typedef logic signed [SINCOS_WIDTH-1:0] sc_t;
    typedef pos_t [2:0] pos_vec_t;
    typedef sc_t  [2:0] sc_vec_t;

    localparam sc_t ONE = SINCOS_WIDTH'(1 << FRAC);

    localparam pos_vec_t C_RST = '0;
    localparam sc_vec_t  U_RST = {sc_t'(0), sc_t'(0), ONE};
    localparam sc_vec_t  V_RST = {sc_t'(0), ONE, sc_t'(0)};
    localparam sc_vec_t  N_RST = {ONE, sc_t'(0), sc_t'(0)};

    typedef struct packed {
        pos_vec_t c;
        sc_vec_t  u;
        sc_vec_t  v;
        sc_vec_t  n;
    } cam_params_t;

    localparam cam_params_t PARAMS_RST = '{c: C_RST, u: U_RST, v: V_RST, n: N_RST};
endpackage

// File: rtl/camera_sched_if.sv
// camera_sched_if: tracker intake, camera request/result and active-bank bundle
interface camera_sched_if
    import camera_sched_pkg::*;
#(
    parameter int HWIDTH = 9,
    parameter int VWIDTH = 8,
    parameter int AWIDTH = 16
) ();
    logic [HWIDTH-1:0] x_in;
    logic [VWIDTH-1:0] y_in;
    logic [AWIDTH-1:0] area_in;
    logic              centroid_valid_in;
    logic              frame_start_in;
    logic [HWIDTH-1:0] cam_x_out;
    logic [VWIDTH-1:0] cam_y_out;
    logic [AWIDTH-1:0] cam_area_out;
    logic              cam_valid_out;
    pos_vec_t          cam_C_in;
    sc_vec_t           cam_u_in;
    sc_vec_t           cam_v_in;
    sc_vec_t           cam_n_in;
    logic              cam_valid_in;
    pos_vec_t          C_out;
    sc_vec_t           u_out;
    sc_vec_t           v_out;
    sc_vec_t           n_out;
    logic              commit_out;
    logic              busy_out;
    logic              timeout_out;

    modport slave (
        input  x_in, y_in, area_in, centroid_valid_in, frame_start_in,
        input  cam_C_in, cam_u_in, cam_v_in, cam_n_in, cam_valid_in,
        output cam_x_out, cam_y_out, cam_area_out, cam_valid_out,
        output C_out, u_out, v_out, n_out, commit_out, busy_out, timeout_out
    );

    modport master (
        output x_in, y_in, area_in, centroid_valid_in, frame_start_in,
        output cam_C_in, cam_u_in, cam_v_in, cam_n_in, cam_valid_in,
        input  cam_x_out, cam_y_out, cam_area_out, cam_valid_out,
        input  C_out, u_out, v_out, n_out, commit_out, busy_out, timeout_out
    );
endinterface

// File: rtl/camera_param_dbuf.sv
// camera_param_dbuf: shadow/active camera bank, committed only on a frame boundary
module camera_param_dbuf
    import camera_sched_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        i_capture,
    input  logic        i_frame_start,
    input  cam_params_t i_data,
    output cam_params_t o_active,
    output logic        o_commit
);
    cam_params_t r_shadow;
    cam_params_t r_active;
    logic        r_shadow_v;
    logic        r_commit;
    logic        w_commit;

    assign w_commit = i_frame_start && r_shadow_v;
    assign o_active = r_active;
    assign o_commit = r_commit;

    // A same-cycle capture refills the shadow after the old value is committed
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_shadow   <= PARAMS_RST;
            r_active   <= PARAMS_RST;
            r_shadow_v <= 1'b0;
            r_commit   <= 1'b0;
        end else begin
            r_commit   <= w_commit;
            if (w_commit) r_active <= r_shadow;
            if (i_capture) r_shadow <= i_data;
            r_shadow_v <= i_capture ? 1'b1 : (w_commit ? 1'b0 : r_shadow_v);
        end
    end
endmodule

// File: rtl/camera_update_scheduler.sv
// camera_update_scheduler: filters tracker samples, issues one camera request at a time, frame-synced commit
module camera_update_scheduler
    import camera_sched_pkg::*;
#(
    parameter int HRES     = 320,
    parameter int VRES     = 180,
    parameter int MIN_AREA = 64,
    parameter int DEADBAND = 2,
    parameter int TIMEOUT  = 64
) (
    input logic           clk_in,
    input logic           rst_in,
    camera_sched_if.slave bus
);
    localparam int HWIDTH = $clog2(HRES);
    localparam int VWIDTH = $clog2(VRES);
    localparam int AWIDTH = $clog2(HRES * VRES);
    localparam int CWIDTH = $clog2(TIMEOUT);

    sched_state_t      r_state;
    logic [HWIDTH-1:0] r_px, r_last_x, r_cam_x, w_dx;
    logic [VWIDTH-1:0] r_py, r_last_y, r_cam_y, w_dy;
    logic [AWIDTH-1:0] r_pa, r_cam_area;
    logic [CWIDTH-1:0] r_cnt;
    logic              r_pv, r_first_done, r_cam_valid, r_timeout;
    logic              w_accept, w_far, w_capture;
    cam_params_t       w_cap_data, w_active;

    assign w_accept  = bus.centroid_valid_in && (bus.area_in >= AWIDTH'(MIN_AREA));
    assign w_dx      = (r_px > r_last_x) ? r_px - r_last_x : r_last_x - r_px;
    assign w_dy      = (r_py > r_last_y) ? r_py - r_last_y : r_last_y - r_py;
    assign w_far     = (w_dx > HWIDTH'(DEADBAND)) || (w_dy > VWIDTH'(DEADBAND));
    assign w_capture = (r_state == WAIT) && bus.cam_valid_in;
    assign w_cap_data = '{c: bus.cam_C_in, u: bus.cam_u_in, v: bus.cam_v_in, n: bus.cam_n_in};

    assign bus.cam_x_out     = r_cam_x;
    assign bus.cam_y_out     = r_cam_y;
    assign bus.cam_area_out  = r_cam_area;
    assign bus.cam_valid_out = r_cam_valid;
    assign bus.timeout_out   = r_timeout;
    assign bus.busy_out      = r_state != IDLE;
    assign bus.C_out         = w_active.c;
    assign bus.u_out         = w_active.u;
    assign bus.v_out         = w_active.v;
    assign bus.n_out         = w_active.n;

    // IDLE either consumes or drops the pending sample, so only a fresh one survives it
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_px         <= '0;
            r_py         <= '0;
            r_pa         <= '0;
            r_pv         <= 1'b0;
            r_last_x     <= '0;
            r_last_y     <= '0;
            r_first_done <= 1'b0;
            r_cnt        <= '0;
            r_cam_x      <= '0;
            r_cam_y      <= '0;
            r_cam_area   <= '0;
            r_cam_valid  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_cam_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_pv        <= ((r_state == IDLE) ? 1'b0 : r_pv) | w_accept;
            if (w_accept) begin
                r_px <= bus.x_in;
                r_py <= bus.y_in;
                r_pa <= bus.area_in;
            end
            case (r_state)
                IDLE: begin
                    if (r_pv && (!r_first_done || w_far)) begin
                        r_state     <= ISSUE;
                        r_cam_valid <= 1'b1;
                        r_cam_x     <= r_px;
                        r_cam_y     <= r_py;
                        r_cam_area  <= r_pa;
                    end
                end
                ISSUE: begin
                    r_last_x     <= r_cam_x;
                    r_last_y     <= r_cam_y;
                    r_first_done <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (bus.cam_valid_in) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CWIDTH'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    camera_param_dbuf u_dbuf (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .i_capture     (w_capture),
        .i_frame_start (bus.frame_start_in),
        .i_data        (w_cap_data),
        .o_active      (w_active),
        .o_commit      (bus.commit_out)
    );
endmodule

// File: tb/tb_camera_update_scheduler.sv
// tb_camera_update_scheduler: directed checks of intake filtering, request timing, timeout and frame commit
module tb_camera_update_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    camera_sched_if #(.HWIDTH(9), .VWIDTH(8), .AWIDTH(16)) bus ();

    camera_update_scheduler dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int x, input int y, input int a);
        bus.x_in = 9'(x);
        bus.y_in = 8'(y);
        bus.area_in = 16'(a);
        bus.centroid_valid_in = 1'b1;
        tick(1);
        bus.centroid_valid_in = 1'b0;
    endtask

    task automatic respond(input logic [53:0] c, input logic [47:0] u);
        bus.cam_C_in = c;
        bus.cam_u_in = u;
        bus.cam_valid_in = 1'b1;
        tick(1);
        bus.cam_valid_in = 1'b0;
    endtask

    initial begin
        bus.x_in = '0;
        bus.y_in = '0;
        bus.area_in = '0;
        bus.centroid_valid_in = 1'b0;
        bus.frame_start_in = 1'b0;
        bus.cam_C_in = '0;
        bus.cam_u_in = '0;
        bus.cam_v_in = {16'd0, 16'h4000, 16'd0};
        bus.cam_n_in = {16'h4000, 16'd0, 16'd0};
        bus.cam_valid_in = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_C", bus.C_out, 54'd0);
        chk("rst_u", bus.u_out, {16'd0, 16'd0, 16'h4000});
        chk("rst_v", bus.v_out, {16'd0, 16'h4000, 16'd0});
        chk("rst_n", bus.n_out, {16'h4000, 16'd0, 16'd0});
        chk("rst_commit", bus.commit_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_cam_valid", bus.cam_valid_out, 0);
        chk("rst_cam_x", bus.cam_x_out, 0);

        sample(100, 50, 1000);
        chk("lat_t1_valid", bus.cam_valid_out, 0);
        tick(1);
        chk("lat_t2_valid", bus.cam_valid_out, 1);
        chk("req_x", bus.cam_x_out, 100);
        chk("req_y", bus.cam_y_out, 50);
        chk("req_area", bus.cam_area_out, 1000);
        tick(1);
        chk("wait_valid_low", bus.cam_valid_out, 0);
        chk("wait_busy", bus.busy_out, 1);
        tick(17);
        respond({18'd3, 18'd2, 18'd1}, {16'h3333, 16'h2222, 16'h1111});
        chk("resp_busy", bus.busy_out, 0);
        chk("pre_commit_C", bus.C_out, 54'd0);
        bus.frame_start_in = 1'b1;
        tick(1);
        bus.frame_start_in = 1'b0;
        chk("commit1", bus.commit_out, 1);
        chk("commit1_C", bus.C_out, {18'd3, 18'd2, 18'd1});
        chk("commit1_u", bus.u_out, {16'h3333, 16'h2222, 16'h1111});
        tick(1);
        chk("commit1_pulse", bus.commit_out, 0);

        sample(101, 50, 1000);
        tick(1);
        chk("deadband_valid", bus.cam_valid_out, 0);
        chk("deadband_busy", bus.busy_out, 0);
        chk("deadband_pv", dut.r_pv, 0);
        sample(103, 50, 1000);
        tick(1);
        chk("x103_valid", bus.cam_valid_out, 1);
        chk("x103_x", bus.cam_x_out, 103);
        tick(1);
        sample(200, 100, 10);
        chk("small_area_pv", dut.r_pv, 0);
        tick(62);
        chk("to_before", bus.timeout_out, 0);
        chk("to_before_busy", bus.busy_out, 1);
        tick(1);
        chk("to_pulse", bus.timeout_out, 1);
        chk("to_busy", bus.busy_out, 0);
        tick(1);
        chk("to_one_cycle", bus.timeout_out, 0);
        chk("to_no_reissue", bus.cam_valid_out, 0);
        bus.frame_start_in = 1'b1;
        tick(1);
        bus.frame_start_in = 1'b0;
        chk("to_no_commit", bus.commit_out, 0);
        chk("to_C_kept", bus.C_out, {18'd3, 18'd2, 18'd1});

        sample(150, 60, 500);
        tick(2);
        respond({18'd30, 18'd20, 18'd10}, {16'h0, 16'h0, 16'h4000});
        chk("A_busy", bus.busy_out, 0);
        chk("A_not_active", bus.C_out, {18'd3, 18'd2, 18'd1});
        sample(160, 60, 500);
        tick(2);
        bus.frame_start_in = 1'b1;
        respond({18'd60, 18'd50, 18'd40}, {16'h0, 16'h0, 16'h4000});
        chk("coll_commit", bus.commit_out, 1);
        chk("coll_C_is_A", bus.C_out, {18'd30, 18'd20, 18'd10});
        tick(1);
        chk("coll_next_commit", bus.commit_out, 1);
        chk("coll_next_C_is_B", bus.C_out, {18'd60, 18'd50, 18'd40});
        tick(1);
        bus.frame_start_in = 1'b0;
        chk("empty_no_commit", bus.commit_out, 0);
        chk("empty_C_kept", bus.C_out, {18'd60, 18'd50, 18'd40});

        sample(200, 100, 500);
        tick(4);
        chk("mid_wait_busy", bus.busy_out, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        respond({18'd7, 18'd7, 18'd7}, {16'h7, 16'h7, 16'h7});
        chk("late_busy", bus.busy_out, 0);
        bus.frame_start_in = 1'b1;
        tick(1);
        bus.frame_start_in = 1'b0;
        chk("late_no_commit", bus.commit_out, 0);
        chk("late_C_rst", bus.C_out, 54'd0);
        chk("late_u_rst", bus.u_out, {16'd0, 16'd0, 16'h4000});

        sample(10, 10, 100);
        tick(1);
        chk("iss_x", bus.cam_x_out, 10);
        sample(20, 30, 200);
        respond({18'd1, 18'd1, 18'd1}, {16'h0, 16'h0, 16'h4000});
        tick(1);
        chk("latest_valid", bus.cam_valid_out, 1);
        chk("latest_x", bus.cam_x_out, 20);
        chk("latest_y", bus.cam_y_out, 30);
        chk("latest_area", bus.cam_area_out, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
